// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures period and high time of a slow asynchronous clock in clk cycles,
// emits clk-domain edge strobes and flags a stalled source. Optional range flag: CLK_MON_RANGE_CHECK_EN.
module clk_period_monitor #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 100000000,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = 1,
  parameter int MAX_PERIOD  = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sense_clk,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             stalled,
  output logic             out_of_range
);

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, STALL} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   synced, rise, fall;
  logic [CNT_W-1:0]       cnt;

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (MIN_PERIOD > MAX_PERIOD) begin : g_chk_range
    $error("MIN_PERIOD must not exceed MAX_PERIOD");
  end

  assign synced = sync[SYNC_STAGES-1];
  assign rise   = synced & ~prev;
  assign fall   = ~synced & prev;

  // Synchronizer and history run regardless of en; only the strobes are gated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= '0;
      prev      <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], sense_clk};
      prev      <= synced;
      rise_tick <= en & rise;
      fall_tick <= en & fall;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A rise seen in the same cycle as cnt==TO wins over the stall.
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:         state_nxt = ARM;
        ARM, MEASURE: if (rise_tick)     state_nxt = MEASURE;
                      else if (cnt == TO) state_nxt = STALL;
        STALL:        if (rise_tick)     state_nxt = MEASURE;
        default:      state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    stalled = (state == STALL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!en || state == IDLE)  cnt <= '0;
      else if (rise_tick)        cnt <= CNT_W'(1);
      else if (cnt != TO)        cnt <= cnt + CNT_W'(1);
      if (en && state == MEASURE && rise_tick) begin
        period       <= cnt;
        period_valid <= 1'b1;
      end
      if (en && state == MEASURE && fall_tick) high_time <= cnt;
    end
  end

`ifdef CLK_MON_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_of_range <= 1'b0;
    else if (!en)
      out_of_range <= 1'b0;
    else if (state == MEASURE && rise_tick)
      out_of_range <= (cnt < CNT_W'(MIN_PERIOD)) || (cnt > CNT_W'(MAX_PERIOD));
    else if (state_nxt == STALL && state != STALL)
      out_of_range <= 1'b1;
  end
`else
  assign out_of_range = 1'b0;
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// Bench for clk_period_monitor: directed table, hand sequences for stall/enable/reset corners,
// and randomized waveforms compared every cycle against a tick-time based reference model.
module tb_clk_period_monitor;
  localparam int TO = 1000, MINP = 150, MAXP = 250, W = 32;
`ifdef CLK_MON_RANGE_CHECK_EN
  localparam bit RANGE_ON = 1'b1;
`else
  localparam bit RANGE_ON = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sense_clk = 1'b0;
  logic rise_tick, fall_tick, period_valid, stalled, out_of_range;
  logic [W-1:0] period, high_time;

  int checks = 0, errors = 0, cyc = 0;
  int n_rise = 0, n_fall = 0, n_pv = 0, n_stall = 0, last_rise_cyc = 0, first_pv_rises = -1;

  always #10 clk = ~clk;

  clk_period_monitor #(.CNT_W(W), .TIMEOUT(TO), .SYNC_STAGES(2),
                       .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP)) dut (
    .clk(clk), .rst(rst), .en(en), .sense_clk(sense_clk),
    .rise_tick(rise_tick), .fall_tick(fall_tick), .period(period), .high_time(high_time),
    .period_valid(period_valid), .stalled(stalled), .out_of_range(out_of_range));

  // Reference model: ticks are sampled input transitions delayed by the sync chain;
  // measurements are distances (in cycles) between tick times, capped at TO.
  bit active, have_ref, m_stalled, m_pv, m_oor, m_rise, m_fall;
  int ref_t, m_period, m_high;
  bit [3:0] sh;

  task automatic model_reset();
    active = 0; have_ref = 0; m_stalled = 0; m_pv = 0; m_oor = 0;
    m_rise = 0; m_fall = 0; m_period = 0; m_high = 0; sh = '0; ref_t = 0;
  endtask

  task automatic model_step(bit e, bit s);
    bit tr, tf;
    int age, capped;
    tr = m_rise; tf = m_fall;
    age = cyc - 1 - ref_t;
    capped = (age > TO) ? TO : age;
    m_pv = 0;
    if (!e) begin
      active = 0; have_ref = 0; m_stalled = 0; m_oor = 0;
    end else if (!active) begin
      active = 1; have_ref = 0; ref_t = cyc;
    end else if (tr) begin
      if (have_ref && !m_stalled) begin
        m_period = capped; m_pv = 1;
        m_oor = RANGE_ON && (capped < MINP || capped > MAXP);
      end
      have_ref = 1; m_stalled = 0; ref_t = cyc - 1;
    end else begin
      if (tf && have_ref && !m_stalled) m_high = capped;
      if (!m_stalled && age >= TO) begin
        m_stalled = 1;
        if (RANGE_ON) m_oor = 1;
      end
    end
    sh = {sh[2:0], s};
    m_rise = e & sh[2] & ~sh[3];
    m_fall = e & ~sh[2] & sh[3];
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(bit e, bit s);
    @(negedge clk);
    en = e; sense_clk = s;
    @(posedge clk);
    cyc++;
    model_step(e, s);
    #1;
    check("flags", {rise_tick, fall_tick, period_valid, stalled, out_of_range},
          {m_rise, m_fall, m_pv, m_stalled, m_oor});
    check("meas", {period, high_time}, {m_period[31:0], m_high[31:0]});
    if (rise_tick) begin n_rise++; last_rise_cyc = cyc; end
    if (fall_tick) n_fall++;
    if (stalled) n_stall++;
    if (period_valid) begin
      n_pv++;
      if (first_pv_rises < 0) first_pv_rises = n_rise;
    end
  endtask

  task automatic run_wave(int hi, int lo, int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < hi; i++) step(1, 1);
      for (int i = 0; i < lo; i++) step(1, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_flags", {rise_tick, fall_tick, period_valid, stalled, out_of_range}, 64'd0);
    check("rst_meas", {period, high_time}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  typedef struct {int hi; int lo; int per; int high; bit oor;} vec_t;
  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit [2:0] lag;
    bit seen;
    int waited, stall_cyc;

    tbl[0] = '{100, 100, 200, 100, 1'b0};
    tbl[1] = '{30,  70,  100, 30,  1'b1};
    tbl[2] = '{150, 150, 300, 150, 1'b1};
    tbl[3] = '{120, 80,  200, 120, 1'b0};
    tbl[4] = '{50,  50,  100, 50,  1'b1};
    tbl[5] = '{60,  190, 250, 60,  1'b0};
    tbl[6] = '{75,  76,  151, 75,  1'b0};
    tbl[7] = '{75,  74,  149, 75,  1'b1};

    // Reset state
    model_reset();
    #5;
    check("init_flags", {rise_tick, fall_tick, period_valid, stalled, out_of_range}, 64'd0);
    check("init_meas", {period, high_time}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Disabled: synchronizer runs, nothing reported
    for (int i = 0; i < 40; i++) step(0, (i / 7) % 2 == 1);
    step(0, 0); step(0, 0); step(0, 0);

    // 200-cycle 50% clock: tick lag, arming rise, first valid period
    for (int i = 0; i < 20; i++) step(1, 0);
    n_pv = 0;
    for (int i = 0; i < 3; i++) begin step(1, 1); lag[i] = rise_tick; end
    check("rise_lag", lag, 3'b100);
    for (int i = 0; i < 97; i++) step(1, 1);
    for (int i = 0; i < 100; i++) step(1, 0);
    check("no_pv_first_rise", n_pv, 0);
    for (int i = 0; i < 5; i++) step(1, 1);
    check("pv_second_rise", n_pv, 1);
    check("period_200", period, 200);
    check("high_100", high_time, 100);
    for (int i = 0; i < 40; i++) step(1, 1);

    // Asynchronous reset mid-measurement
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1);

    // Directed table
    foreach (tbl[t]) begin
      n_fall = 0;
      run_wave(tbl[t].hi, tbl[t].lo, 3);
      check("tbl_falls", n_fall, 3);
      for (int i = 0; i < 6; i++) step(1, 1);
      check("tbl_period", period, tbl[t].per);
      check("tbl_high", high_time, tbl[t].high);
      check("tbl_oor", out_of_range, RANGE_ON & tbl[t].oor);
    end

    // Stall: exactly TO+1 cycles after the last rise tick
    seen = 0; waited = 0; stall_cyc = 0;
    while (!seen && waited < 1500) begin
      step(1, 0);
      waited++;
      if (stalled) begin seen = 1; stall_cyc = cyc; end
    end
    check("stall_seen", seen, 1'b1);
    check("stall_delay", stall_cyc - last_rise_cyc, TO + 1);
    n_pv = 0;
    for (int i = 0; i < 5; i++) step(1, 1);
    check("stall_cleared", stalled, 1'b0);
    check("restart_no_pv", n_pv, 0);
    for (int i = 0; i < 95; i++) step(1, 1);
    for (int i = 0; i < 100; i++) step(1, 0);
    for (int i = 0; i < 5; i++) step(1, 1);
    check("restart_pv", n_pv, 1);
    check("restart_period", period, 200);

    // Rise coinciding with cnt==TO: period TO reported, no stall
    for (int i = 0; i < 95; i++) step(1, 1);
    for (int i = 0; i < 100; i++) step(1, 0);
    n_stall = 0;
    run_wave(500, 500, 2);
    for (int i = 0; i < 6; i++) step(1, 1);
    check("period_at_timeout", period, TO);
    check("no_stall_at_timeout", n_stall, 0);

    // Enable dropped mid-measure
    for (int i = 0; i < 10; i++) step(0, 1);
    check("en_drop_stalled", stalled, 1'b0);
    check("en_drop_period_held", period, TO);
    n_rise = 0; first_pv_rises = -1;
    run_wave(100, 100, 3);
    for (int i = 0; i < 6; i++) step(1, 1);
    check("reenable_pv_on_second_rise", first_pv_rises, 2);

    // Randomized waveforms, enables, stalls and resets against the model
    for (int seg = 0; seg < 30; seg++) begin
      int hi, lo, r, d;
      hi = $urandom_range(1, 300);
      lo = $urandom_range(1, 300);
      r  = $urandom_range(0, 19);
      if (r == 0) lo = TO + $urandom_range(1, 200);
      for (int i = 0; i < hi; i++) step(1, 1);
      if (r == 1) begin
        d = $urandom_range(1, 20);
        for (int i = 0; i < d; i++) step(0, 1'($urandom_range(0, 1)));
      end
      if (r == 2) do_reset();
      for (int i = 0; i < lo; i++) step(1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
